bno055_i2c_responder: RTL
=========================

# bno055_i2c_responder

I2C target that emulates the BNO055 register interface, the responder end of the BNO055 read/write transaction master. It sits on the same SCL/SDA pair as the master, either in a testbench or in a loop-back build on the Go Board. It lets the configure-then-poll sequence run without a physical sensor. It decodes START/STOP, matches its 7-bit address, and serves a register file with auto-incrementing pointer reads and writes.

## Interface
- DEV_ADDR, 7'h28: 7-bit target address.
- REG_DEPTH, 64: number of implemented registers, at addresses 0..REG_DEPTH-1.
- MODE_DELAY, 16'd1000: busy window in i_clk cycles. Used only with the configuration macro.
- i_clk  in  1  system clock; one clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_scl  in  1  SCL pin; asynchronous. This block never stretches the clock.
- i_sda  in  1  SDA pin; asynchronous.
- o_sda_oe  out  1  1 = pull SDA low. The top level ties the pin to 0 when o_sda_oe is 1, else to high-Z.
- o_wr_valid  out  1  one-cycle strobe per accepted register write.
- o_wr_addr  out  8  register address of the write.
- o_wr_data  out  8  data of the write.
- o_opr_mode  out  8  current contents of register 0x3D (OPR_MODE).
- o_busy  out  1  high from START until STOP whenever the address matched.

## Operation
- **Input synchronisers:** SCL and SDA each pass through a 2-flop synchroniser, followed by a previous-value register.
  - Edge and START/STOP detection use the synchronised values only.
  - i_clk must be at least 16x the SCL rate.
- **Bus conditions:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Either condition is recognised in any state. It overrides the state in progress and releases SDA.
- **State machine:**
  - IDLE: START -> ADDR.
  - ADDR: shift in 8 bits (MSB first) on SCL rising edges.
    - Address match -> ADDR_ACK.
    - Mismatch -> IGNORE.
  - ADDR_ACK: drive ACK.
    - R/W=0 -> PTR.
    - R/W=1 -> load the shift register with reg[ptr], then go to RD_DATA.
  - PTR: the first byte after a write address becomes the pointer -> PTR_ACK -> WR_DATA.
  - WR_DATA: shift in a byte -> WR_ACK. On WR_ACK, write reg[ptr], increment ptr, then return to WR_DATA.
  - RD_DATA: drive 8 bits -> RD_ACK. Sample the master's ACK bit on the SCL rising edge.
    - ACK (SDA low): increment ptr, load reg[ptr], return to RD_DATA.
    - NACK: go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
  - A STOP in any state -> IDLE. A START in any state -> ADDR, which covers repeated starts.
- **SDA drive:**
  - o_sda_oe changes only on a synchronised SCL falling edge.
  - ACK is asserted on the falling edge that ends bit 8 and released on the falling edge that ends bit 9.
- **Pointer:**
  - 8 bits; wraps 0xFF -> 0x00.
  - It persists across transactions until the next write sets it.
- **Reset register values:** 0x00=A0, 0x01=FB, 0x02=32, 0x03=0F. All other registers are 00, including 0x3D.
- **Read-only registers (0x00-0x03):** writes are ACKed but ignored, with no o_wr_valid.
- **Out-of-range addresses (>= REG_DEPTH):** reads return 00; writes are ACKed and discarded, with no strobe.

## Timing
- Reset state: IDLE; ptr=00; register file at its reset values.
- Output reset values: o_sda_oe=0, o_wr_valid=0, o_wr_addr=00, o_wr_data=00, o_opr_mode=00, o_busy=0.
- Edge-detection latency: a synchronised edge is acted on 3 i_clk cycles after the pin change.
- o_wr_valid, o_wr_addr and o_wr_data update in the cycle after the SCL rising edge that samples bit 8 of the data byte.
  - o_opr_mode follows in the same cycle.
- Reset asserted mid-transfer: SDA is released immediately (asynchronously) and the register file returns to its reset values.
- A START or STOP received mid-byte discards the partial byte. No write takes place.

## Configuration
- **BNO055_RESP_MODE_DELAY_EN defined:** every accepted write to 0x3D starts a MODE_DELAY-cycle counter.
  - While the counter is nonzero, address phases NACK, even when the address matches. This emulates the sensor's mode-switch time.
  - The counter is cleared by reset.
- **Macro undefined:** the counter logic is absent and the address is always ACKed on a match.

## Test plan
- Reset; write ptr=00; repeated START; read 4 bytes with master ACK,ACK,ACK,NACK -> A0 FB 32 0F; SDA released after the NACK.
- Write 0x3D=0B -> o_wr_valid pulses once with addr=3D, data=0B; o_opr_mode=0B; reading back 0x3D returns 0B.
- Address 0x29, then 0x28 with R/W=1 before any write (ptr=00) -> 9th bit NACK (SDA released, o_busy=0, no register change); for 0x28 the read returns A0.
- Write 0x00=55 and 0x50=AA -> both ACKed, no o_wr_valid; register 0x00 reads A0; register 0x50 reads 00.
- STOP after 4 bits of a data byte, then assert i_rst_n low mid-read -> no write occurs; o_sda_oe=0 at once; o_opr_mode=00.
- With BNO055_RESP_MODE_DELAY_EN: write 0x3D=0B, then immediately address 0x28 -> NACK; after MODE_DELAY cycles -> ACK.

Source files
------------

// File: rtl/bno055_i2c_responder.sv
// I2C target emulating the BNO055 register map: START/STOP decode, address match,
// auto-incrementing register pointer. Optional mode-switch busy window: BNO055_RESP_MODE_DELAY_EN.
module bno055_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR   = 7'h28,
  parameter int unsigned REG_DEPTH  = 64,
  parameter logic [15:0] MODE_DELAY = 16'd1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic [7:0] o_opr_mode,
  output logic       o_busy
);

  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [7:0] OprModeAddr = 8'h3D;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  // Sync flops reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= i_scl;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= i_sda;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   = scl_sync & ~scl_prev;
  assign scl_fall   = ~scl_sync & scl_prev;
  assign start_cond = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_cond  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_en;
  logic        addr_hold;

  logic [7:0]  regs_q [REG_DEPTH];
  logic [7:0]  rx_byte, ptr_inc, rd_cur, rd_next;
  logic        cur_in_range, next_in_range, writable;

  assign rx_byte       = {shift_q, sda_sync};
  assign ptr_inc       = ptr_q + 8'd1;
  assign cur_in_range  = ({24'd0, ptr_q} < REG_DEPTH);
  assign next_in_range = ({24'd0, ptr_inc} < REG_DEPTH);
  assign rd_cur        = cur_in_range ? regs_q[ptr_q[AW-1:0]] : 8'h00;
  assign rd_next       = next_in_range ? regs_q[ptr_inc[AW-1:0]] : 8'h00;
  assign writable      = cur_in_range && (ptr_q >= 8'h04);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    wr_en    = 1'b0;
    if (stop_cond) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_cond) begin
      state_d  = StAddr;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: ;
        StAddr, StPtr, StWrData: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              case (state_q)
                StAddr: begin
                  if (rx_byte[7:1] == DEV_ADDR && !addr_hold) begin
                    state_d = StAddrAck;
                    rw_d    = rx_byte[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d = StIgnore;
                    busy_d  = 1'b0;
                  end
                end
                StPtr: begin
                  ptr_d   = rx_byte;
                  state_d = StPtrAck;
                end
                default: begin
                  wr_en   = 1'b1;
                  ptr_d   = ptr_inc;
                  state_d = StWrAck;
                end
              endcase
            end
          end
        end
        // cnt 0: before the 9th rising edge; cnt 1: after it.
        StAddrAck, StPtrAck, StWrAck: begin
          if (scl_rise) begin
            cnt_d = 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
            end else begin
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
              if (state_q == StAddrAck && rw_q) begin
                tx_d     = rd_cur;
                sda_oe_d = ~rd_cur[7];
                state_d  = StRdData;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWrData;
              end
            end
          end
        end
        StRdData: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = StRdAck;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (!sda_sync) begin
              ptr_d = ptr_inc;
              tx_d  = rd_next;
              cnt_d = 4'd1;
            end else begin
              state_d = StIgnore;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            sda_oe_d = ~tx_q[7];
            cnt_d    = 4'd0;
            state_d  = StRdData;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      shift_q  <= 7'd0;
      tx_q     <= 8'd0;
      ptr_q    <= 8'd0;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
    end
  end

  function automatic logic [7:0] reset_value(input int unsigned idx);
    case (idx)
      0:       reset_value = 8'hA0;
      1:       reset_value = 8'hFB;
      2:       reset_value = 8'h32;
      3:       reset_value = 8'h0F;
      default: reset_value = 8'h00;
    endcase
  endfunction

  logic       wr_valid_q;
  logic [7:0] wr_addr_q, wr_data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs_q[i] <= reset_value(i);
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
    end else begin
      wr_valid_q <= wr_en && writable;
      if (wr_en && writable) begin
        regs_q[ptr_q[AW-1:0]] <= rx_byte;
        wr_addr_q             <= ptr_q;
        wr_data_q             <= rx_byte;
      end
    end
  end

`ifdef BNO055_RESP_MODE_DELAY_EN
  logic [15:0] delay_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      delay_q <= 16'd0;
    end else if (wr_en && writable && ptr_q == OprModeAddr) begin
      delay_q <= MODE_DELAY;
    end else if (delay_q != 16'd0) begin
      delay_q <= delay_q - 16'd1;
    end
  end

  assign addr_hold = (delay_q != 16'd0);
`else
  assign addr_hold = 1'b0;
`endif

  assign o_sda_oe   = sda_oe_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_opr_mode = regs_q[OprModeAddr[AW-1:0]];
  assign o_busy     = busy_q;

endmodule
